if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high (`RstEnable` = 1'b1).
REQ-003 SHALL have port stall  input  6  pipeline stall vector; bit0 = PC, bit1 = IF, bit2 = ID; bits 5:3 ignored.
REQ-004 SHALL have port flush  input  1  exception flush; redirects PC to new_pc.
REQ-005 SHALL have port new_pc  input  32  exception handler address.
REQ-006 SHALL have port branch_flag_i  input  1  taken branch/jump from ID.
REQ-007 SHALL have port branch_target_address_i  input  32  branch/jump target.
REQ-008 SHALL have port rom_ce  output  1  instruction ROM chip enable (`ChipEnable` = 1).
REQ-009 SHALL have port rom_addr  output  32  instruction byte address to ROM.
REQ-010 SHALL have port rom_inst  input  32  instruction word returned combinationally by ROM for rom_addr.
REQ-011 SHALL have port id_pc  output  32  IF/ID register: PC of captured instruction.
REQ-012 SHALL have port id_inst  output  32  IF/ID register: captured instruction word.
REQ-013 SHALL have port id_misaligned  output  1  IF/ID register: captured PC had pc[1:0] != 0.
REQ-014 SHALL have port fetch_cnt  output  32  count of valid instructions delivered to ID.

Function
REQ-015 SHALL hold internal registers ce (1 bit) and pc (32 bits); rom_ce = ce and rom_addr = pc, both purely from registers.
REQ-016 ce SHALL be 0 during reset and become 1 on the first clock edge with rst = 0; it stays 1 until next reset.
REQ-017 While ce = 0, pc SHALL be loaded with 0x00000000.
REQ-018 While ce = 1, pc next-value priority SHALL be: flush -> new_pc; else stall[0] = 1 -> hold; else branch_flag_i -> branch_target_address_i; else pc + 4.
REQ-019 pc + 4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000) with no flag.
REQ-020 Taken branches SHALL NOT squash the instruction already fetched (MIPS delay slot executes).
REQ-021 IF/ID register next-value priority SHALL be: flush -> bubble; else stall[1] = 1 and stall[2] = 0 -> bubble; else stall[1] = 1 -> hold; else capture.
REQ-022 Bubble SHALL mean id_pc = 0, id_inst = 0 (`ZeroWord`), id_misaligned = 0.
REQ-023 Capture SHALL load id_pc = pc; if ce = 0 load id_inst = 0 and id_misaligned = 0; else if pc[1:0] != 2'b00 load id_inst = 0 and id_misaligned = 1; else load id_inst = rom_inst and id_misaligned = 0.
REQ-024 fetch_cnt SHALL increment by 1 on each capture with ce = 1 and pc[1:0] = 2'b00, wrap 0xFFFFFFFF -> 0, and hold otherwise.
REQ-025 Simultaneous flush and branch_flag_i SHALL resolve to flush for both pc and IF/ID.
REQ-026 Simultaneous flush and stall SHALL resolve to flush (flush overrides all stall bits).
REQ-027 stall[0] = 1 with stall[1] = 0 SHALL capture the same instruction again each cycle (caller's responsibility; no detection).

Reset
REQ-028 With rst = 1 at a clock edge: ce = 0, pc = 0x00000000, id_pc = 0, id_inst = 0, id_misaligned = 0, fetch_cnt = 0.
REQ-029 rst SHALL override flush, stall and branch inputs; reset asserted mid-stall or mid-branch discards all pending state.
REQ-030 Outputs SHALL be well-defined (no X) from the first edge with rst = 1.

Verification
REQ-031 Reset release, no stalls, ROM word i = 0x34010000 + i: rom_addr sequence 0,0,4,8,...; id_inst = 0x34010000 one cycle after rom_addr = 0, then 0x34010001,...; fetch_cnt increments each cycle after first valid capture.
REQ-032 branch_flag_i = 1, target 0x00000100, when pc = 0x10: next rom_addr 0x100; instruction at 0x10 (delay slot) still appears in id_inst.
REQ-033 stall = 6'b000011 for 3 cycles at pc = 0x20: pc holds 0x20, IF/ID holds bubble (zeros) for 3 cycles, fetch_cnt frozen; release resumes at 0x20 then 0x24.
REQ-034 stall = 6'b000111: pc and IF/ID both hold values unchanged; flush = 1 with new_pc = 0x00000040 in same cycle -> pc = 0x40, IF/ID bubble.
REQ-035 branch target 0x00000102: id_misaligned = 1, id_inst = 0, id_pc = 0x102, fetch_cnt unchanged; then pc = 0x106.
REQ-036 rst = 1 asserted while pc = 0xFFFFFFFC and stall[0] = 1: next edge all outputs zero, ce = 0; one cycle after release rom_addr = 0, rom_ce = 1.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, ROM request, IF/ID pipeline register
// and a running count of valid instructions handed to decode.
module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_misaligned,
    output logic [31:0] fetch_cnt
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 32;

    logic          ce;
    logic [AW-1:0] pc;

    logic [AW-1:0] pc_next_c;
    logic [AW-1:0] id_pc_next_c;
    logic [DW-1:0] id_inst_next_c;
    logic          id_mis_next_c;
    logic          cnt_inc_c;

    // Upper stall bits belong to later stages and do not affect fetch.
    logic unused_stall;
    assign unused_stall = ^stall[5:3];

    assign rom_ce   = ce;
    assign rom_addr = pc;

    // PC select: flush beats stall beats branch beats sequential.
    always_comb begin
        pc_next_c = pc + AW'(4);
        if (!ce) begin
            pc_next_c = '0;
        end else if (flush) begin
            pc_next_c = new_pc;
        end else if (stall[0]) begin
            pc_next_c = pc;
        end else if (branch_flag_i) begin
            pc_next_c = branch_target_address_i;
        end
    end

    // IF/ID select; a stalled IF with a running ID must inject a bubble.
    always_comb begin
        id_pc_next_c   = id_pc;
        id_inst_next_c = id_inst;
        id_mis_next_c  = id_misaligned;
        cnt_inc_c      = 1'b0;
        if (flush || (stall[1] && !stall[2])) begin
            id_pc_next_c   = '0;
            id_inst_next_c = '0;
            id_mis_next_c  = 1'b0;
        end else if (!stall[1]) begin
            id_pc_next_c = pc;
            if (!ce) begin
                id_inst_next_c = '0;
                id_mis_next_c  = 1'b0;
            end else if (pc[1:0] != 2'b00) begin
                id_inst_next_c = '0;
                id_mis_next_c  = 1'b1;
            end else begin
                id_inst_next_c = rom_inst;
                id_mis_next_c  = 1'b0;
                cnt_inc_c      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ce            <= 1'b0;
            pc            <= '0;
            id_pc         <= '0;
            id_inst       <= '0;
            id_misaligned <= 1'b0;
            fetch_cnt     <= '0;
        end else begin
            ce            <= 1'b1;
            pc            <= pc_next_c;
            id_pc         <= id_pc_next_c;
            id_inst       <= id_inst_next_c;
            id_misaligned <= id_mis_next_c;
            if (cnt_inc_c) begin
                fetch_cnt <= fetch_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, delay slot, stalls, flush,
// misaligned targets, PC wrap and reset override.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_misaligned;
    logic [31:0] fetch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    if_stage dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .rom_ce                  (rom_ce),
        .rom_addr                (rom_addr),
        .rom_inst                (rom_inst),
        .id_pc                   (id_pc),
        .id_inst                 (id_inst),
        .id_misaligned           (id_misaligned),
        .fetch_cnt               (fetch_cnt)
    );

    // ROM word i holds 0x34010000 + i.
    assign rom_inst = 32'h3401_0000 + (rom_addr >> 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic ce_e, input logic [31:0] pc_e,
                              input logic [31:0] ipc_e, input logic [31:0] inst_e,
                              input logic mis_e, input logic [31:0] cnt_e);
        chk({tag, ".rom_ce"},   32'(rom_ce), 32'(ce_e));
        chk({tag, ".rom_addr"}, rom_addr, pc_e);
        chk({tag, ".id_pc"},    id_pc, ipc_e);
        chk({tag, ".id_inst"},  id_inst, inst_e);
        chk({tag, ".id_mis"},   32'(id_misaligned), 32'(mis_e));
        chk({tag, ".cnt"},      fetch_cnt, cnt_e);
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0;
        branch_flag_i = 1'b0; branch_target_address_i = '0;

        tick();
        tick();
        expect_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        rst = 1'b0;
        tick(); expect_all("rel1", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        tick(); expect_all("seq0", 1'b1, 32'h4, 32'h0, 32'h3401_0000, 1'b0, 32'd1);
        tick(); expect_all("seq1", 1'b1, 32'h8, 32'h4, 32'h3401_0001, 1'b0, 32'd2);
        tick(); expect_all("seq2", 1'b1, 32'hC, 32'h8, 32'h3401_0002, 1'b0, 32'd3);
        tick(); expect_all("seq3", 1'b1, 32'h10, 32'hC, 32'h3401_0003, 1'b0, 32'd4);

        // Branch taken at pc 0x10; the delay slot still reaches ID.
        branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
        tick(); expect_all("br_slot", 1'b1, 32'h100, 32'h10, 32'h3401_0004, 1'b0, 32'd5);
        branch_flag_i = 1'b0;
        tick(); expect_all("br_tgt", 1'b1, 32'h104, 32'h100, 32'h3401_0040, 1'b0, 32'd6);

        branch_flag_i = 1'b1; branch_target_address_i = 32'h20;
        tick(); expect_all("br_20", 1'b1, 32'h20, 32'h104, 32'h3401_0041, 1'b0, 32'd7);
        branch_flag_i = 1'b0;

        // PC+IF stalled, ID running: bubbles, pc frozen.
        stall = 6'b000011;
        tick(); expect_all("stl_a", 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 32'd7);
        tick(); expect_all("stl_b", 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 32'd7);
        tick(); expect_all("stl_c", 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 32'd7);
        stall = '0;
        tick(); expect_all("stl_rel", 1'b1, 32'h24, 32'h20, 32'h3401_0008, 1'b0, 32'd8);

        // Full hold, then flush overriding the stall.
        stall = 6'b000111;
        tick(); expect_all("hold", 1'b1, 32'h24, 32'h20, 32'h3401_0008, 1'b0, 32'd8);
        flush = 1'b1; new_pc = 32'h40;
        tick(); expect_all("fl_stl", 1'b1, 32'h40, 32'h0, 32'h0, 1'b0, 32'd8);
        flush = 1'b0; stall = '0;
        tick(); expect_all("fl_res", 1'b1, 32'h44, 32'h40, 32'h3401_0010, 1'b0, 32'd9);

        // Misaligned branch target.
        branch_flag_i = 1'b1; branch_target_address_i = 32'h102;
        tick(); expect_all("mis_br", 1'b1, 32'h102, 32'h44, 32'h3401_0011, 1'b0, 32'd10);
        branch_flag_i = 1'b0;
        tick(); expect_all("mis_a", 1'b1, 32'h106, 32'h102, 32'h0, 1'b1, 32'd10);
        tick(); expect_all("mis_b", 1'b1, 32'h10A, 32'h106, 32'h0, 1'b1, 32'd10);

        // Flush and branch together: flush wins.
        flush = 1'b1; new_pc = 32'h80;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
        tick(); expect_all("fl_br", 1'b1, 32'h80, 32'h0, 32'h0, 1'b0, 32'd10);
        flush = 1'b0; branch_flag_i = 1'b0;
        tick(); expect_all("fl_br2", 1'b1, 32'h84, 32'h80, 32'h3401_0020, 1'b0, 32'd11);

        // PC wrap at the top of the address space.
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        tick(); expect_all("wrap_a", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd11);
        flush = 1'b0;
        tick(); expect_all("wrap_b", 1'b1, 32'h0, 32'hFFFF_FFFC, 32'h7400_FFFF, 1'b0, 32'd12);

        // Reset while stalled at the top address.
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        tick(); expect_all("pre_rst", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd12);
        flush = 1'b0; stall = 6'b000001; rst = 1'b1;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h300;
        tick(); expect_all("rst_mid", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        rst = 1'b0; stall = '0; branch_flag_i = 1'b0;
        tick(); expect_all("rst_rel", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        tick(); expect_all("rst_seq", 1'b1, 32'h4, 32'h0, 32'h3401_0000, 1'b0, 32'd1);

        // PC stalled but IF capturing: same instruction re-captured.
        stall = 6'b000001;
        tick(); expect_all("recap_a", 1'b1, 32'h4, 32'h4, 32'h3401_0001, 1'b0, 32'd2);
        tick(); expect_all("recap_b", 1'b1, 32'h4, 32'h4, 32'h3401_0001, 1'b0, 32'd3);
        stall = '0;
        tick(); expect_all("recap_c", 1'b1, 32'h8, 32'h4, 32'h3401_0001, 1'b0, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
